// File: rtl/demux_serial_1x4.sv
// Round-robin de-interleaver: collects a serial byte stream into 4-byte frames and presents
// each frame on four lanes at once, flushing partial frames after an idle timeout.
module demux_serial_1x4 #(
    parameter int IDLE_MAX = 4
) (
    input  logic       clk,
    input  logic       reset_L,
    input  logic       valid_in,
    input  logic [7:0] data_in,
    output logic [7:0] data_out0,
    output logic [7:0] data_out1,
    output logic [7:0] data_out2,
    output logic [7:0] data_out3,
    output logic       valid_out0,
    output logic       valid_out1,
    output logic       valid_out2,
    output logic       valid_out3,
    output logic       flush
);

    localparam int CW = (IDLE_MAX > 0) ? $clog2(IDLE_MAX + 1) : 1;
    localparam logic [CW-1:0] CNT_MAX  = CW'(IDLE_MAX);
    localparam logic [CW-1:0] CNT_LAST = CW'((IDLE_MAX > 0) ? IDLE_MAX - 1 : 0);

    typedef enum logic {
        IDLE,
        FILL
    } state_e;

    state_e          state_q, state_d;
    logic [1:0]      ptr_q, ptr_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [7:0]      stage_q [4];
    logic [7:0]      stage_d [4];
    logic [7:0]      data_q  [4];
    logic [7:0]      data_d  [4];
    logic [3:0]      valid_q, valid_d;
    logic            flush_q, flush_d;

    // NOTE: every _d gets a default first so no path through the case can infer a latch.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        stage_d = stage_q;
        data_d  = data_q;
        valid_d = 4'b0000;
        flush_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (valid_in) begin
                    stage_d[0] = data_in;
                    ptr_d      = 2'd1;
                    cnt_d      = '0;
                    state_d    = FILL;
                end
            end
            FILL: begin
                if (valid_in) begin
                    cnt_d = '0;
                    if (ptr_q == 2'd3) begin
                        // The 4th byte goes straight to lane3, bypassing staging.
                        data_d[0] = stage_q[0];
                        data_d[1] = stage_q[1];
                        data_d[2] = stage_q[2];
                        data_d[3] = data_in;
                        valid_d   = 4'b1111;
                        ptr_d     = 2'd0;
                        state_d   = IDLE;
                    end else begin
                        stage_d[ptr_q] = data_in;
                        ptr_d          = ptr_q + 2'd1;
                    end
                end else if (IDLE_MAX != 0) begin
                    if (cnt_q == CNT_LAST) begin
                        for (int i = 0; i < 4; i++) begin
                            if (i < int'(ptr_q)) begin
                                data_d[i]  = stage_q[i];
                                valid_d[i] = 1'b1;
                            end
                        end
                        flush_d = 1'b1;
                        cnt_d   = '0;
                        ptr_d   = 2'd0;
                        state_d = IDLE;
                    end else if (cnt_q != CNT_MAX) begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                ptr_d   = 2'd0;
                cnt_d   = '0;
            end
        endcase
    end

    // NOTE: staging registers are deliberately reset so a discarded partial frame leaves no trace.
    always_ff @(posedge clk) begin
        if (!reset_L) begin
            state_q <= IDLE;
            ptr_q   <= 2'd0;
            cnt_q   <= '0;
            valid_q <= 4'b0000;
            flush_q <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                stage_q[i] <= 8'h00;
                data_q[i]  <= 8'h00;
            end
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
            flush_q <= flush_d;
            stage_q <= stage_d;
            data_q  <= data_d;
        end
    end

    assign data_out0  = data_q[0];
    assign data_out1  = data_q[1];
    assign data_out2  = data_q[2];
    assign data_out3  = data_q[3];
    assign valid_out0 = valid_q[0];
    assign valid_out1 = valid_q[1];
    assign valid_out2 = valid_q[2];
    assign valid_out3 = valid_q[3];
    assign flush      = flush_q;

endmodule

// File: tb/tb_demux_serial_1x4.sv
// Directed bench for demux_serial_1x4: default-timeout instance plus an IDLE_MAX=0 instance
// sharing the same stimulus.
module tb_demux_serial_1x4;

    logic       clk = 1'b0;
    logic       reset_L = 1'b0;
    logic       valid_in = 1'b0;
    logic [7:0] data_in = 8'h00;

    logic [7:0] d0, d1, d2, d3;
    logic       v0, v1, v2, v3, fl;
    logic [7:0] z0, z1, z2, z3;
    logic       zv0, zv1, zv2, zv3, zfl;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    demux_serial_1x4 #(.IDLE_MAX(4)) dut (
        .clk(clk), .reset_L(reset_L), .valid_in(valid_in), .data_in(data_in),
        .data_out0(d0), .data_out1(d1), .data_out2(d2), .data_out3(d3),
        .valid_out0(v0), .valid_out1(v1), .valid_out2(v2), .valid_out3(v3),
        .flush(fl)
    );

    demux_serial_1x4 #(.IDLE_MAX(0)) dut_nt (
        .clk(clk), .reset_L(reset_L), .valid_in(valid_in), .data_in(data_in),
        .data_out0(z0), .data_out1(z1), .data_out2(z2), .data_out3(z3),
        .valid_out0(zv0), .valid_out1(zv1), .valid_out2(zv2), .valid_out3(zv3),
        .flush(zfl)
    );

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Expected lanes packed as {lane0,lane1,lane2,lane3}; valid as {v3,v2,v1,v0}.
    task automatic check_out(input string tag, input logic [31:0] exp_data,
                             input logic [3:0] exp_valid, input logic exp_flush);
        check({tag, "_data"},  {d0, d1, d2, d3}, exp_data);
        check({tag, "_valid"}, {28'd0, v3, v2, v1, v0}, {28'd0, exp_valid});
        check({tag, "_flush"}, {31'd0, fl}, {31'd0, exp_flush});
    endtask

    task automatic check_nt(input string tag, input logic [31:0] exp_data,
                            input logic [3:0] exp_valid, input logic exp_flush);
        check({tag, "_data"},  {z0, z1, z2, z3}, exp_data);
        check({tag, "_valid"}, {28'd0, zv3, zv2, zv1, zv0}, {28'd0, exp_valid});
        check({tag, "_flush"}, {31'd0, zfl}, {31'd0, exp_flush});
    endtask

    // Apply inputs, clock once, sample 1 time unit after the edge.
    task automatic step(input logic v, input logic [7:0] d);
        valid_in = v;
        data_in  = d;
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset
        reset_L = 1'b0;
        step(1'b1, 8'hEE);
        step(1'b0, 8'h00);
        check_out("reset", 32'h00000000, 4'b0000, 1'b0);
        check_nt("reset_nt", 32'h00000000, 4'b0000, 1'b0);
        reset_L = 1'b1;

        // T1: single full frame
        step(1'b1, 8'h11);
        step(1'b1, 8'h22);
        step(1'b1, 8'h33);
        check_out("t1_fill", 32'h00000000, 4'b0000, 1'b0);
        step(1'b1, 8'h44);
        check_out("t1_frame", 32'h11223344, 4'b1111, 1'b0);
        step(1'b0, 8'h00);
        check_out("t1_hold", 32'h11223344, 4'b0000, 1'b0);

        // T2: back-to-back frames, 4 cycles apart
        step(1'b1, 8'hA0);
        step(1'b1, 8'hA1);
        step(1'b1, 8'hA2);
        step(1'b1, 8'hA3);
        check_out("t2_frame0", 32'hA0A1A2A3, 4'b1111, 1'b0);
        step(1'b1, 8'hA4);
        check_out("t2_gap1", 32'hA0A1A2A3, 4'b0000, 1'b0);
        step(1'b1, 8'hA5);
        step(1'b1, 8'hA6);
        check_out("t2_gap3", 32'hA0A1A2A3, 4'b0000, 1'b0);
        step(1'b1, 8'hA7);
        check_out("t2_frame1", 32'hA4A5A6A7, 4'b1111, 1'b0);
        step(1'b0, 8'h00);

        // T3: two bytes then timeout flush
        step(1'b1, 8'h55);
        step(1'b1, 8'h66);
        step(1'b0, 8'h00);
        step(1'b0, 8'h00);
        step(1'b0, 8'h00);
        check_out("t3_idle3", 32'hA4A5A6A7, 4'b0000, 1'b0);
        step(1'b0, 8'h00);
        check_out("t3_flush", 32'h5566A6A7, 4'b0011, 1'b1);
        step(1'b0, 8'h00);
        check_out("t3_after", 32'h5566A6A7, 4'b0000, 1'b0);

        // T4: 3 idle cycles between bytes never time out
        step(1'b1, 8'h01);
        for (int i = 0; i < 3; i++) step(1'b0, 8'h00);
        step(1'b1, 8'h02);
        for (int i = 0; i < 3; i++) step(1'b0, 8'h00);
        check_out("t4_noflush", 32'h5566A6A7, 4'b0000, 1'b0);
        step(1'b1, 8'h03);
        for (int i = 0; i < 3; i++) step(1'b0, 8'h00);
        step(1'b1, 8'h04);
        check_out("t4_frame", 32'h01020304, 4'b1111, 1'b0);

        // T4b: single-byte flush touches lane0 only
        step(1'b1, 8'h5A);
        for (int i = 0; i < 4; i++) step(1'b0, 8'h00);
        check_out("t4b_flush", 32'h5A020304, 4'b0001, 1'b1);

        // T5: reset discards a partial frame
        step(1'b1, 8'hC1);
        step(1'b1, 8'hC2);
        reset_L = 1'b0;
        step(1'b0, 8'h00);
        check_out("t5_reset", 32'h00000000, 4'b0000, 1'b0);
        reset_L = 1'b1;
        step(1'b1, 8'hD1);
        step(1'b1, 8'hD2);
        step(1'b1, 8'hD3);
        check_out("t5_fill", 32'h00000000, 4'b0000, 1'b0);
        step(1'b1, 8'hD4);
        check_out("t5_frame", 32'hD1D2D3D4, 4'b1111, 1'b0);
        check_nt("t5_frame_nt", 32'hD1D2D3D4, 4'b1111, 1'b0);

        // T6: IDLE_MAX=0 instance never flushes
        step(1'b1, 8'h77);
        for (int i = 0; i < 20; i++) begin
            step(1'b0, 8'h00);
            check_nt("t6_idle", 32'hD1D2D3D4, 4'b0000, 1'b0);
        end
        step(1'b1, 8'h88);
        step(1'b1, 8'h99);
        step(1'b1, 8'hAA);
        check_nt("t6_frame", 32'h778899AA, 4'b1111, 1'b0);
        step(1'b0, 8'h00);
        check_nt("t6_after", 32'h778899AA, 4'b0000, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
